mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Single-port memory arbiter that shares one RAM port between the instruction-fetch requester and the data (load/store) requester of the pipelined datapath.
- Sits between the datapath's fetch and memory stages and the RAM.
- Data requests have priority, with a bounded starvation guard for fetch.
- Sequences each access through a small state machine, registers the read data, and returns one-cycle hit pulses.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced.
TIMEOUT, 255, cycles to wait for ram_ready before aborting an access with an error.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
iREN  in  1  instruction read request; held until ihit.
iaddr  in  ADDR_W  instruction address.
dREN  in  1  data read request; held until dhit.
dWEN  in  1  data write request; held until dhit. dREN and dWEN are never both 1.
daddr  in  ADDR_W  data address.
dstore  in  DATA_W  data to write.
ihit  out  1  one-cycle pulse: instruction access complete.
iload  out  DATA_W  fetched instruction, valid when ihit=1.
dhit  out  1  one-cycle pulse: data access complete.
dload  out  DATA_W  load data, valid when dhit=1 after dREN.
err  out  1  one-cycle pulse together with the hit when the access timed out.
ram_ren  out  1  RAM read strobe.
ram_wen  out  1  RAM write strobe.
ram_addr  out  ADDR_W  RAM address.
ram_store  out  DATA_W  RAM write data.
ram_load  in  DATA_W  RAM read data, valid when ram_ready=1.
ram_ready  in  1  RAM access completes this cycle.

Behaviour:
- Reset (asynchronous, nRST=0): state=IDLE.
- Reset values: all outputs 0, iload=dload=0, streak counter=0, timeout counter=0, latched address/data=0.
- States: IDLE, DACC, IACC, DONE.
- IDLE arbitration, in priority order:
  - If (dREN|dWEN) and not (iREN and streak==MAX_DSTREAK): go to DACC. Latch daddr, dstore and write flag. If iREN=1, streak+=1 (saturating); otherwise streak=0.
  - Else if iREN: go to IACC, latch iaddr, streak=0.
  - Else stay in IDLE.
- DACC/IACC:
  - Drive ram_addr from the latched address; ram_ren/ram_wen from the latched type (IACC is always a read); ram_store from the latched data.
  - RAM strobes are driven only in these states; otherwise ram_* outputs are 0.
  - Timeout counter increments each cycle the state is held.
  - On ram_ready=1: capture ram_load into iload (IACC) or dload (DACC read), then go to DONE.
  - If the counter reaches TIMEOUT without ram_ready: go to DONE with the error flag set; the captured load data is 0.
- DONE: pulse exactly one of ihit/dhit for one cycle, plus err if flagged. Clear the timeout counter and error flag. Go to IDLE.
- Load data persistence: iload/dload hold their values until the next completion of the same type.
- Latency: with ram_ready=1 on the first access cycle, hit occurs 2 cycles after the request is first seen in IDLE (IDLE→xACC→DONE). Each RAM wait cycle adds 1.
- Requester handshake: each requester drops or changes its request in the cycle after its hit. IDLE then arbitrates fresh.
- Input stability: request inputs changing while in xACC/DONE have no effect, because the address and data are latched.
- Simultaneous iREN and dREN in IDLE: data wins unless streak==MAX_DSTREAK, in which case fetch wins and streak resets.
- Write completion: a data write completes with dhit; dload is unchanged.
- Reset mid-access: the access is abandoned immediately, no hit is produced, and the RAM strobes drop asynchronously.
- Hit exclusivity: ihit and dhit are never 1 in the same cycle.

Test Plan:
1. Fetch only: iREN=1, iaddr=0x40, ram_ready=1 always, ram_load=0x2108000A → ram_ren=1 with ram_addr=0x40 one cycle after the request; ihit=1 with iload=0x2108000A on the following cycle.
2. Simultaneous requests: iREN=1 (0x100), dREN=1 (0x200), ram_ready=1 → data serviced first (dhit); fetch follows (ihit after the next IDLE); no overlap of hits.
3. Starvation guard, MAX_DSTREAK=4: dREN held continuously with iREN=1 → 4 dhits, then ihit on the 5th grant, then data resumes.
4. Store with wait states: dWEN=1, daddr=0x80, dstore=0xDEADBEEF, ram_ready asserted on the 3rd access cycle → ram_wen=1 and ram_store=0xDEADBEEF held for 3 cycles; then dhit; dload unchanged; ram_ren=0 throughout.
5. Timeout, TIMEOUT=8: dREN=1, ram_ready held 0 → after 8 access cycles, dhit=1 and err=1 in the same cycle, dload=0, state returns to IDLE.
6. Reset mid-access: nRST pulled low during IACC → all outputs 0 immediately; after release, no ihit until a new request is serviced.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Data has priority; a bounded streak counter keeps fetch from starving.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              err,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready
);

  localparam int unsigned SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] StreakMax = SW'(MAX_DSTREAK);
  localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StDacc, StIacc, StDone} state_e;

  state_e        state_q;
  logic [SW-1:0] streak_q;
  logic [TW-1:0] tmo_q;
  logic          d_go;

  // Data wins unless fetch has already waited out a full data streak.
  assign d_go = (dREN | dWEN) & ~(iREN & (streak_q == StreakMax));

  // RAM strobes are the latched access itself, so they double as address/type latches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      tmo_q     <= '0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      err       <= 1'b0;
      iload     <= '0;
      dload     <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_go) begin
            state_q   <= StDacc;
            ram_addr  <= daddr;
            ram_store <= dstore;
            ram_ren   <= dREN;
            ram_wen   <= dWEN;
            if (!iREN) begin
              streak_q <= '0;
            end else if (streak_q != StreakMax) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (iREN) begin
            state_q   <= StIacc;
            ram_addr  <= iaddr;
            ram_store <= '0;
            ram_ren   <= 1'b1;
            ram_wen   <= 1'b0;
            streak_q  <= '0;
          end
        end
        StDacc, StIacc: begin
          if (ram_ready || (tmo_q == TmoLast)) begin
            state_q   <= StDone;
            tmo_q     <= '0;
            err       <= ~ram_ready;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            if (state_q == StIacc) begin
              ihit  <= 1'b1;
              iload <= ram_ready ? ram_load : '0;
            end else begin
              dhit <= 1'b1;
              if (ram_ren) dload <= ram_ready ? ram_load : '0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ihit    <= 1'b0;
          dhit    <= 1'b0;
          err     <= 1'b0;
          tmo_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
